// File: rtl/watchdog_multichannel_if.sv
// Bus interface for watchdog_multichannel: monitored values, per-channel
// enables/clears and the alert vectors returned to the aggregator.
// Optional macro WATCHDOG_RUNTIME_TIMEOUT_EN adds the timeout_cycles signal.
interface watchdog_multichannel_if #(
  parameter int channel_count        = 4,
  parameter int bitwidth             = 8,
  parameter int value_change_timeout = 16
);
  localparam int TimeoutWidth = $clog2(value_change_timeout + 1);

  logic [channel_count*bitwidth-1:0] monitored_values;
  logic [channel_count-1:0]          channel_enable;
  logic [channel_count-1:0]          clear;
  logic [channel_count-1:0]          alert_value_changed;
  logic [channel_count-1:0]          alert_value_unchanged;
  logic                              alert_any;
`ifdef WATCHDOG_RUNTIME_TIMEOUT_EN
  logic [TimeoutWidth-1:0]           timeout_cycles;
`endif

  // Stimulus / controlling side.
  modport master (
    output monitored_values,
    output channel_enable,
    output clear,
    input  alert_value_changed,
    input  alert_value_unchanged,
    input  alert_any
`ifdef WATCHDOG_RUNTIME_TIMEOUT_EN
    ,
    output timeout_cycles
`endif
  );

  // Watchdog side.
  modport slave (
    input  monitored_values,
    input  channel_enable,
    input  clear,
    output alert_value_changed,
    output alert_value_unchanged,
    output alert_any
`ifdef WATCHDOG_RUNTIME_TIMEOUT_EN
    ,
    input  timeout_cycles
`endif
  );
endinterface

// File: rtl/watchdog_multichannel.sv
// Multi-channel watchdog: per channel, a sticky alert on any change of the
// sampled value and a sticky alert when the value stays unchanged for a
// timeout of consecutive primed edges. Channels are fully independent.
// Optional macro WATCHDOG_RUNTIME_TIMEOUT_EN: the timeout comes from the
// bus signal timeout_cycles (0 treated as 1) instead of the parameter.
module watchdog_multichannel #(
  parameter int channel_count                   = 4,
  parameter int bitwidth                        = 8,
  parameter int enable_alert_on_value_change    = 1,
  parameter int enable_alert_on_value_unchanged = 1,
  parameter int value_change_timeout            = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  watchdog_multichannel_if.slave bus
);
  localparam int CW = $clog2(value_change_timeout + 1);
  localparam logic [CW-1:0] PARAM_LIMIT = CW'(value_change_timeout);
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic ENABLE_CHANGE    = (enable_alert_on_value_change != 0);
  localparam logic ENABLE_UNCHANGED = (enable_alert_on_value_unchanged != 0);

  logic [CW-1:0]            timeout_limit;
  logic [CW-1:0]            limit_minus_one;
  logic [channel_count-1:0] changed_vec;
  logic [channel_count-1:0] unchanged_vec;

`ifdef WATCHDOG_RUNTIME_TIMEOUT_EN
  // Runtime limit shared by all channels; zero would never time out, so it
  // behaves as one.
  assign timeout_limit = (bus.timeout_cycles == '0) ? ONE : bus.timeout_cycles;
`else
  assign timeout_limit = PARAM_LIMIT;
`endif

  // Setting the alert on "counter about to reach the limit" also covers a
  // runtime limit lowered below an in-flight count.
  assign limit_minus_one = timeout_limit - ONE;

  for (genvar gi = 0; gi < channel_count; gi++) begin : g_channel
    logic [bitwidth-1:0] sample;
    logic [bitwidth-1:0] reference_q, reference_d;
    logic                primed_q, primed_d;
    logic [CW-1:0]       counter_q, counter_d;
    logic                changed_q, changed_d;
    logic                unchanged_q, unchanged_d;
    logic                change;

    assign sample = bus.monitored_values[gi*bitwidth +: bitwidth];
    assign change = primed_q && (sample != reference_q);

    // Channel state register with asynchronous clear of everything.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        reference_q <= '0;
        primed_q    <= 1'b0;
        counter_q   <= '0;
        changed_q   <= 1'b0;
        unchanged_q <= 1'b0;
      end else begin
        reference_q <= reference_d;
        primed_q    <= primed_d;
        counter_q   <= counter_d;
        changed_q   <= changed_d;
        unchanged_q <= unchanged_d;
      end
    end

    // Next-state: priming, change detection, timeout counting, sticky alerts;
    // clear is applied last so it wins over a same-edge set.
    always_comb begin
      reference_d = sample;
      primed_d    = bus.channel_enable[gi];
      counter_d   = counter_q;
      changed_d   = changed_q;
      unchanged_d = unchanged_q;

      if (!bus.channel_enable[gi]) begin
        // Idle channel: no counting, alerts frozen, re-enable will re-prime.
        counter_d = '0;
      end else if (change || !primed_q) begin
        // Priming edge or a real change restarts the stability window.
        counter_d = '0;
        if (change && ENABLE_CHANGE) begin
          changed_d = 1'b1;
        end
      end else begin
        counter_d = (counter_q >= timeout_limit) ? timeout_limit : counter_q + ONE;
        if (ENABLE_UNCHANGED && (counter_q >= limit_minus_one)) begin
          unchanged_d = 1'b1;
        end
      end

      if (bus.clear[gi]) begin
        changed_d   = 1'b0;
        unchanged_d = 1'b0;
        counter_d   = '0;
      end
    end

    assign changed_vec[gi]   = changed_q;
    assign unchanged_vec[gi] = unchanged_q;
  end

  assign bus.alert_value_changed   = changed_vec;
  assign bus.alert_value_unchanged = unchanged_vec;
  assign bus.alert_any             = (|changed_vec) | (|unchanged_vec);
endmodule

// File: tb/tb_watchdog_multichannel.sv
// Directed bench for watchdog_multichannel (4 channels x 8 bits, timeout 16).
module tb_watchdog_multichannel;
  localparam int CH  = 4;
  localparam int BW  = 8;
  localparam int VCT = 16;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  watchdog_multichannel_if #(
    .channel_count(CH), .bitwidth(BW), .value_change_timeout(VCT)
  ) bus ();

  watchdog_multichannel #(
    .channel_count(CH),
    .bitwidth(BW),
    .enable_alert_on_value_change(1),
    .enable_alert_on_value_unchanged(1),
    .value_change_timeout(VCT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-24s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_alerts(input string tag, input logic [3:0] chg, input logic [3:0] unc);
    check({tag, ".chg"}, {28'd0, bus.alert_value_changed}, {28'd0, chg});
    check({tag, ".unc"}, {28'd0, bus.alert_value_unchanged}, {28'd0, unc});
    check({tag, ".any"}, {31'd0, bus.alert_any}, {31'd0, (|chg) | (|unc)});
  endtask

  // Advance n rising edges, then park on the falling edge for sampling/driving.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_ch(input int idx, input logic [7:0] val);
    bus.monitored_values[idx*BW +: BW] = val;
  endtask

  initial begin
    reset                = 1'b0;
    bus.monitored_values = '0;
    bus.channel_enable   = 4'b1111;
    bus.clear            = 4'b0000;
`ifdef WATCHDOG_RUNTIME_TIMEOUT_EN
    bus.timeout_cycles   = 5'd16;
`endif
    #1;
    check_alerts("reset", 4'b0000, 4'b0000);
    @(negedge clock);
    reset = 1'b1;

    // Stable zeros: priming edge, then 15 unchanged edges give nothing,
    // the 16th unchanged edge sets every timeout alert.
    step(1);
    step(15);
    check_alerts("stable15", 4'b0000, 4'b0000);
    step(1);
    check_alerts("stable16", 4'b0000, 4'b1111);

    // Clear everything, then change channel 2 on the third edge.
    bus.clear = 4'b1111;
    step(1);
    bus.clear = 4'b0000;
    check_alerts("clear_all", 4'b0000, 4'b0000);
    step(2);
    set_ch(2, 8'h5A);
    step(1);
    check_alerts("ch2_change", 4'b0100, 4'b0000);
    step(13);
    check_alerts("others_timeout", 4'b0100, 4'b1011);
    step(2);
    check_alerts("ch2_pending", 4'b0100, 4'b1011);
    step(1);
    check_alerts("ch2_timeout", 4'b0100, 4'b1111);

    // Disabled channels hold alerts despite input changes; clear still works.
    bus.channel_enable = 4'b0000;
    set_ch(0, 8'h33);
    set_ch(3, 8'h44);
    step(1);
    check_alerts("disabled_hold", 4'b0100, 4'b1111);
    bus.monitored_values = '0;
    bus.clear = 4'b1111;
    step(1);
    bus.clear = 4'b0000;
    check_alerts("disabled_clear", 4'b0000, 4'b0000);

    // Re-enable with ch0 at 0xFF against a reference of 0x00: priming only.
    set_ch(0, 8'hFF);
    bus.channel_enable = 4'b1111;
    step(1);
    check_alerts("prime_ff", 4'b0000, 4'b0000);
    set_ch(0, 8'hFE);
    step(1);
    check_alerts("ff_to_fe", 4'b0001, 4'b0000);

    // Clear on the same edge as a ch1 change wins; the next change sets.
    bus.clear = 4'b1111;
    step(1);
    check_alerts("clear_ch0", 4'b0000, 4'b0000);
    set_ch(1, 8'h11);
    bus.clear = 4'b0010;
    step(1);
    bus.clear = 4'b0000;
    check_alerts("clear_beats_chg", 4'b0000, 4'b0000);
    set_ch(1, 8'h22);
    step(1);
    check_alerts("ch1_change", 4'b0010, 4'b0000);

    // Asynchronous reset with counters at 9 and an alert pending.
    bus.clear = 4'b1111;
    step(1);
    bus.clear = 4'b0000;
    set_ch(3, 8'h07);
    step(1);
    check_alerts("pre_reset", 4'b1000, 4'b0000);
    step(8);
    #2;
    reset = 1'b0;
    #1;
    check_alerts("async_reset", 4'b0000, 4'b0000);
    @(negedge clock);
    reset = 1'b1;
    step(1);
    check_alerts("post_reset_prime", 4'b0000, 4'b0000);
    step(15);
    check_alerts("post_reset15", 4'b0000, 4'b0000);
    step(1);
    check_alerts("post_reset16", 4'b0000, 4'b1111);

`ifdef WATCHDOG_RUNTIME_TIMEOUT_EN
    // Runtime timeout of 3, then 0 which acts as 1.
    bus.timeout_cycles = 5'd3;
    bus.clear = 4'b1111;
    step(1);
    bus.clear = 4'b0000;
    step(2);
    check_alerts("rt3_two", 4'b0000, 4'b0000);
    step(1);
    check_alerts("rt3_three", 4'b0000, 4'b1111);
    bus.timeout_cycles = 5'd0;
    bus.clear = 4'b1111;
    step(1);
    bus.clear = 4'b0000;
    check_alerts("rt0_cleared", 4'b0000, 4'b0000);
    step(1);
    check_alerts("rt0_one", 4'b0000, 4'b1111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
